// File: rtl/tse_soft_reset_sequencer.sv
// Host-side soft-reset sequencer: merges reset requests, holds them for a fixed
// time, then releases the selected lines one at a time in ascending order.
module tse_soft_reset_sequencer #(
    parameter int                 NUM_RST     = 8,
    parameter int                 HOLD_CYCLES = 64,
    parameter int                 RELEASE_GAP = 16,
    parameter int                 CW          = 8,
    parameter logic [NUM_RST-1:0] SPEED_MASK  = {NUM_RST{1'b1}}
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_RST-1:0] sreset_req,
    input  logic               req_strobe,
    input  logic               global_req,
    input  logic               speed_chg,
    output logic [NUM_RST-1:0] rst_out,
    output logic               busy,
    output logic               done,
    output logic [NUM_RST-1:0] active_mask
);

    localparam int IW = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_RST - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(RELEASE_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ASSERT,
        S_RELEASE,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [NUM_RST-1:0] active_q, active_d;
    logic [NUM_RST-1:0] pending_q, pending_d;
    logic [NUM_RST-1:0] rst_out_q, rst_out_d;
    logic [NUM_RST-1:0] new_req;
    logic [NUM_RST-1:0] next_mask;

    always_comb begin
        new_req = (req_strobe ? sreset_req : '0)
                | (global_req ? {NUM_RST{1'b1}} : '0)
                | (speed_chg  ? SPEED_MASK : '0);
        next_mask = pending_q | new_req;

        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        active_d  = active_q;
        rst_out_d = rst_out_q;
        // Requests seen while busy queue up for the next sequence, never the current one.
        pending_d = next_mask;

        case (state_q)
            S_IDLE, S_DONE: begin
                pending_d = '0;
                if (next_mask != '0) begin
                    active_d  = next_mask;
                    rst_out_d = next_mask;
                    cnt_d     = HOLD_LD;
                    state_d   = S_ASSERT;
                end else begin
                    active_d  = '0;
                    rst_out_d = '0;
                    state_d   = S_IDLE;
                end
            end
            S_ASSERT: begin
                if (cnt_q == '0) begin
                    idx_d   = '0;
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RELEASE: begin
                if (active_q[idx_q]) begin
                    rst_out_d[idx_q] = 1'b0;
                    cnt_d            = GAP_LD;
                    state_d          = S_GAP;
                end else if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = S_RELEASE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Reset behaves as a full-mask request already in its hold phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_ASSERT;
            cnt_q     <= HOLD_LD;
            idx_q     <= '0;
            active_q  <= {NUM_RST{1'b1}};
            pending_q <= '0;
            rst_out_q <= {NUM_RST{1'b1}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            rst_out_q <= rst_out_d;
        end
    end

    assign rst_out     = rst_out_q;
    assign active_mask = active_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_tse_soft_reset_sequencer.sv
// Bench for tse_soft_reset_sequencer: table vectors, directed corner sequences and
// random traffic against a timeline reference model.
module tb_tse_soft_reset_sequencer;

    localparam int N = 4;
    localparam int H = 4;
    localparam int G = 2;
    localparam logic [N-1:0] SPD = 4'b1000;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] sreset_req = '0;
    logic         req_strobe = 1'b0;
    logic         global_req = 1'b0;
    logic         speed_chg = 1'b0;
    logic [N-1:0] rst_out;
    logic         busy;
    logic         done;
    logic [N-1:0] active_mask;

    tse_soft_reset_sequencer #(
        .NUM_RST(N), .HOLD_CYCLES(H), .RELEASE_GAP(G), .CW(8), .SPEED_MASK(SPD)
    ) dut (
        .clk(clk), .reset(reset), .sreset_req(sreset_req), .req_strobe(req_strobe),
        .global_req(global_req), .speed_chg(speed_chg), .rst_out(rst_out),
        .busy(busy), .done(done), .active_mask(active_mask)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int done_seen = 0;
    int idle_seen = 0;

    // Reference model: a sequence is a start cycle plus a mask; per-bit release
    // cycles and the done cycle follow from the hold/gap arithmetic.
    bit           m_valid = 0;
    bit           m_busy = 0;
    logic [N-1:0] m_mask = '0;
    logic [N-1:0] m_pend = '0;
    int           m_rel[N];
    int           m_done_c = -1;

    task automatic m_start(input int s, input logic [N-1:0] m);
        int t;
        m_busy = 1;
        m_mask = m;
        m_pend = '0;
        t = s + H;
        for (int i = 0; i < N; i++) begin
            if (m[i]) begin
                m_rel[i] = t + 1;
                t += 1 + G;
            end else begin
                m_rel[i] = 0;
                t += 1;
            end
        end
        m_done_c = t;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic stb, input logic [N-1:0] msk,
                        input logic g, input logic sp);
        logic [N-1:0] nw;
        logic [N-1:0] e_rst;
        logic [N-1:0] p;
        if (m_valid) begin
            for (int i = 0; i < N; i++) e_rst[i] = m_busy && m_mask[i] && (cyc < m_rel[i]);
            check("model", {22'd0, rst_out, busy, done, active_mask},
                  {22'd0, e_rst, m_busy, (m_busy && cyc == m_done_c), (m_busy ? m_mask : 4'd0)});
            if (done === 1'b1) done_seen++;
            if (busy !== 1'b1) idle_seen++;
        end
        reset = r; req_strobe = stb; sreset_req = msk; global_req = g; speed_chg = sp;
        nw = (stb ? msk : '0) | (g ? {N{1'b1}} : '0) | (sp ? SPD : '0);
        if (r) begin
            m_start(cyc + 1, {N{1'b1}});
            m_valid = 1;
        end else if (m_valid) begin
            if (!m_busy) begin
                if (nw != '0) m_start(cyc + 1, nw);
            end else if (cyc == m_done_c) begin
                p = m_pend | nw;
                if (p != '0) m_start(cyc + 1, p);
                else begin
                    m_busy = 0;
                    m_pend = '0;
                end
            end else begin
                m_pend |= nw;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic         stb;
        logic [N-1:0] msk;
        logic [N-1:0] e_rst;
        logic         e_busy;
        logic         e_done;
    } vec_t;

    function automatic vec_t mk(input logic stb, input logic [N-1:0] msk,
                                input logic [N-1:0] e_rst, input logic e_busy, input logic e_done);
        vec_t v;
        v.stb = stb; v.msk = msk; v.e_rst = e_rst; v.e_busy = e_busy; v.e_done = e_done;
        return v;
    endfunction

    vec_t tbl[17];

    initial begin
        // Masked request 0101 from idle, then a zero-mask strobe that must do nothing.
        tbl[0]  = mk(1, 4'b0101, 4'b0000, 0, 0);
        for (int i = 1; i <= 5; i++)  tbl[i] = mk(0, 4'b0000, 4'b0101, 1, 0);
        for (int i = 6; i <= 9; i++)  tbl[i] = mk(0, 4'b0000, 4'b0100, 1, 0);
        for (int i = 10; i <= 12; i++) tbl[i] = mk(0, 4'b0000, 4'b0000, 1, 0);
        tbl[13] = mk(0, 4'b0000, 4'b0000, 1, 1);
        tbl[14] = mk(0, 4'b0000, 4'b0000, 0, 0);
        tbl[15] = mk(1, 4'b0000, 4'b0000, 0, 0);
        tbl[16] = mk(0, 4'b0000, 4'b0000, 0, 0);

        // Power-on: reset for 3 cycles, then a full sequence with no request.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        check("reset_rst_out", rst_out, 4'hF);
        check("reset_busy_done", {busy, done}, 2'b10);
        done_seen = 0;
        for (int k = 0; k < 4; k++) begin
            check("por_hold", rst_out, 4'hF);
            idle(1);
        end
        idle(16);
        check("por_done_once", done_seen, 1);
        check("por_idle_busy", busy, 1'b0);

        // Table vectors.
        for (int i = 0; i < 17; i++) begin
            check($sformatf("tbl%0d", i), {rst_out, busy, done}, {tbl[i].e_rst, tbl[i].e_busy, tbl[i].e_done});
            step(1'b0, tbl[i].stb, tbl[i].msk, 1'b0, 1'b0);
        end

        // Request during GAP chains straight into a second sequence.
        step(1'b0, 1'b1, 4'b0001, 1'b0, 1'b0);
        done_seen = 0; idle_seen = 0;
        idle(5);
        step(1'b0, 1'b1, 4'b0010, 1'b0, 1'b0);
        idle(5);
        check("chain_active", active_mask, 4'b0010);
        idle(11);
        check("chain_done_cnt", done_seen, 2);
        check("chain_no_idle", idle_seen, 0);
        check("chain_end_idle", busy, 1'b0);

        // Strobe and speed change in the same idle cycle merge.
        step(1'b0, 1'b1, 4'b0001, 1'b0, 1'b1);
        check("merge_active", active_mask, 4'b1001);
        idle(6);
        check("merge_bit0_first", rst_out, 4'b1000);
        idle(10);
        check("merge_end_idle", busy, 1'b0);

        // Reset mid-sequence discards a pending request.
        step(1'b0, 1'b1, 4'b0001, 1'b0, 1'b0);
        idle(5);
        step(1'b0, 1'b1, 4'b0100, 1'b0, 1'b0);
        check("mid_bit0_low", rst_out, 4'b0000);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        check("mid_reset_ones", rst_out, 4'hF);
        done_seen = 0;
        idle(20);
        check("mid_done_once", done_seen, 1);
        check("mid_end_idle", busy, 1'b0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 19) == 0), 4'($urandom),
                 ($urandom_range(0, 99) == 0), ($urandom_range(0, 59) == 0));
        end
        idle(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
